// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction geometry, opcode encodings and the
// state encoding of the front-panel button debouncer.
package cpu_pkg;

  localparam int INSTR_W  = 18;
  localparam int OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] LOAD    = 3'd0;
  localparam logic [OPCODE_W-1:0] ADD     = 3'd1;
  localparam logic [OPCODE_W-1:0] ADDI    = 3'd2;
  localparam logic [OPCODE_W-1:0] SUB     = 3'd3;
  localparam logic [OPCODE_W-1:0] SUBI    = 3'd4;
  localparam logic [OPCODE_W-1:0] MULT    = 3'd5;
  localparam logic [OPCODE_W-1:0] CLEAR   = 3'd6;
  localparam logic [OPCODE_W-1:0] DISPLAY = 3'd7;

  localparam logic [1:0] DB_RELEASED     = 2'd0;
  localparam logic [1:0] DB_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] DB_PRESSED      = 2'd2;
  localparam logic [1:0] DB_RELEASE_WAIT = 2'd3;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes the active-low send button and emits a single-cycle accept
// strobe once a press has been stable for DEBOUNCE_CYCLES samples.
module button_debounce
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic send_n,
  output logic accept
);

  localparam int             CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  ONE    = CW'(1);
  localparam logic [CW-1:0]  LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit             SINGLE = (DEBOUNCE_CYCLES == 1);

  logic          sync1;
  logic          sync2;
  logic [1:0]    state;
  logic [CW-1:0] count;

  // NOTE: every register here uses <= so all flops sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      state  <= DB_RELEASED;
      count  <= '0;
      accept <= 1'b0;
    end else begin
      sync1  <= send_n;
      sync2  <= sync1;
      accept <= 1'b0;
      case (state)
        DB_RELEASED: begin
          if (!sync2) begin
            if (SINGLE) begin
              state  <= DB_PRESSED;
              accept <= 1'b1;
            end else begin
              state <= DB_PRESS_WAIT;
            end
            count <= ONE;
          end
        end
        DB_PRESS_WAIT: begin
          if (sync2) begin
            state <= DB_RELEASED;
            count <= '0;
          end else begin
            count <= count + ONE;
            if (count == LAST) begin
              state  <= DB_PRESSED;
              accept <= 1'b1;
            end
          end
        end
        DB_PRESSED: begin
          if (sync2) begin
            state <= SINGLE ? DB_RELEASED : DB_RELEASE_WAIT;
            count <= ONE;
          end
        end
        DB_RELEASE_WAIT: begin
          // A release is the mirror of a press but never strobes accept.
          if (!sync2) begin
            state <= DB_PRESSED;
            count <= '0;
          end else begin
            count <= count + ONE;
            if (count == LAST) state <= DB_RELEASED;
          end
        end
        default: state <= DB_RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/instr_capture.sv
// Captures debounced switch instructions on each KEY3 press into a small
// FIFO that a downstream consumer drains with a valid/ready handshake.
module instr_capture
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          send_n,
  input  logic [INSTR_W-1:0]            switches,
  output logic [INSTR_W-1:0]            instr,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int               AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      FULL = (AW + 1)'(FIFO_DEPTH);

  logic               accept;
  logic [INSTR_W-1:0] sw_sync1;
  logic [INSTR_W-1:0] sw_sync2;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [INSTR_W-1:0] mem [FIFO_DEPTH];
  logic               full;
  logic               pop;
  logic               push;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .send_n (send_n),
    .accept (accept)
  );

  assign full        = (fifo_count == FULL);
  assign instr_valid = (fifo_count != '0);
  assign pop         = instr_valid && instr_ready;
  // A full FIFO still takes a new entry when the head leaves in the same cycle.
  assign push        = accept && (!full || pop);
  assign instr       = instr_valid ? mem[rd_ptr] : '0;

  // NOTE: storage has no reset; the read mux above hides stale contents when empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sw_sync2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_sync1   <= '0;
      sw_sync2   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      sw_sync1 <= switches;
      sw_sync2 <= sw_sync1;
      overflow <= accept && full && !pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_capture.sv
// Directed bench for instr_capture with DEBOUNCE_CYCLES = 4, FIFO_DEPTH = 4;
// one task per scenario, each with its own inline comparisons.
module tb_instr_capture;
  import cpu_pkg::*;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        send_n = 1'b1;
  logic [17:0] switches = '0;
  logic [17:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [2:0]  fifo_count;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  int ovf_pulses = 0;

  instr_capture #(
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .send_n     (send_n),
    .switches   (switches),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (overflow === 1'b1) ovf_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    send_n = 1'b1;
    instr_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic press(input logic [17:0] value, input int hold);
    switches = value;
    send_n = 1'b0;
    repeat (hold) tick();
    send_n = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b expected 0", instr_valid);
    end
    checks++;
    if (fifo_count !== 3'd0) begin
      failures++; $display("FAIL reset_count: got %0d expected 0", fifo_count);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL reset_overflow: got %b expected 0", overflow);
    end
    checks++;
    if (instr !== 18'h0) begin
      failures++; $display("FAIL reset_instr: got %h expected 00000", instr);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_press();
    int base;
    apply_reset();
    base = ovf_pulses;
    switches = 18'h0A123;
    send_n = 1'b0;
    repeat (6) tick();
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL latency_early: got valid=%b expected 0 at cycle 6", instr_valid);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1) begin
      failures++; $display("FAIL latency_valid: got valid=%b expected 1 at cycle 7", instr_valid);
    end
    checks++;
    if (instr !== 18'h0A123) begin
      failures++; $display("FAIL single_instr: got %h expected 0a123", instr);
    end
    checks++;
    if (fifo_count !== 3'd1) begin
      failures++; $display("FAIL single_count: got %0d expected 1", fifo_count);
    end
    repeat (3) tick();
    send_n = 1'b1;
    repeat (12) tick();
    checks++;
    if (fifo_count !== 3'd1 || ovf_pulses - base !== 0) begin
      failures++;
      $display("FAIL single_hold: got count=%0d ovf=%0d expected 1 and 0", fifo_count, ovf_pulses - base);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    switches = 18'h3FFFF;
    for (int p = 0; p < 3; p++) begin
      send_n = 1'b0;
      repeat (3) tick();
      send_n = 1'b1;
      repeat (3) tick();
    end
    repeat (8) tick();
    checks++;
    if (fifo_count !== 3'd0) begin
      failures++; $display("FAIL glitch_short: got count=%0d expected 0", fifo_count);
    end
    for (int i = 0; i < 20; i++) begin
      send_n = (i % 2 == 1);
      tick();
    end
    send_n = 1'b1;
    repeat (12) tick();
    checks++;
    if (fifo_count !== 3'd0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL glitch_bounce: got count=%0d valid=%b expected 0 and 0", fifo_count, instr_valid);
    end
  endtask

  task automatic test_overflow();
    logic [17:0] vals [5];
    int base;
    vals = '{{LOAD, 15'h1001}, {ADD, 15'h2202}, {ADDI, 15'h3303},
             {SUB, 15'h4404}, {DISPLAY, 15'h5505}};
    apply_reset();
    base = ovf_pulses;
    for (int i = 0; i < 4; i++) begin
      press(vals[i], 10);
      checks++;
      if (fifo_count !== 3'(i + 1)) begin
        failures++; $display("FAIL fill_count_%0d: got %0d expected %0d", i, fifo_count, i + 1);
      end
    end
    checks++;
    if (ovf_pulses - base !== 0) begin
      failures++; $display("FAIL fill_no_overflow: got %0d pulses expected 0", ovf_pulses - base);
    end
    press(vals[4], 10);
    checks++;
    if (fifo_count !== 3'd4) begin
      failures++; $display("FAIL overflow_count: got %0d expected 4", fifo_count);
    end
    checks++;
    if (ovf_pulses - base !== 1) begin
      failures++; $display("FAIL overflow_pulse: got %0d pulse cycles expected 1", ovf_pulses - base);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (instr !== vals[i] || instr_valid !== 1'b1) begin
        failures++;
        $display("FAIL pop_order_%0d: got %h valid=%b expected %h valid=1", i, instr, instr_valid, vals[i]);
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
    end
    checks++;
    if (fifo_count !== 3'd0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL drained: got count=%0d valid=%b expected 0 and 0", fifo_count, instr_valid);
    end
    instr_ready = 1'b1;
    repeat (3) tick();
    instr_ready = 1'b0;
    checks++;
    if (fifo_count !== 3'd0) begin
      failures++; $display("FAIL ready_when_empty: got count=%0d expected 0", fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] vals [4];
    logic [17:0] expect_q [4];
    logic [17:0] newest;
    int base;
    vals = '{{SUBI, 15'h0A0A}, {MULT, 15'h1B1B}, {CLEAR, 15'h2C2C}, {DISPLAY, 15'h3D3D}};
    newest = {ADD, 15'h7E7E};
    base = ovf_pulses;
    for (int i = 0; i < 4; i++) press(vals[i], 10);
    checks++;
    if (fifo_count !== 3'd4) begin
      failures++; $display("FAIL b2b_full: got count=%0d expected 4", fifo_count);
    end
    switches = newest;
    send_n = 1'b0;
    repeat (6) tick();
    checks++;
    if (instr !== vals[0]) begin
      failures++; $display("FAIL b2b_head_stable: got %h expected %h", instr, vals[0]);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++;
    if (fifo_count !== 3'd4) begin
      failures++; $display("FAIL b2b_count: got %0d expected 4", fifo_count);
    end
    repeat (3) tick();
    send_n = 1'b1;
    repeat (12) tick();
    checks++;
    if (ovf_pulses - base !== 0) begin
      failures++; $display("FAIL b2b_no_overflow: got %0d pulses expected 0", ovf_pulses - base);
    end
    expect_q = '{vals[1], vals[2], vals[3], newest};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (instr !== expect_q[i]) begin
        failures++; $display("FAIL b2b_pop_%0d: got %h expected %h", i, instr, expect_q[i]);
      end
      checks++;
      if (opcode_of(instr) !== opcode_of(expect_q[i])) begin
        failures++;
        $display("FAIL b2b_opcode_%0d: got %0d expected %0d", i, opcode_of(instr), opcode_of(expect_q[i]));
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_drained: got valid=%b expected 0", instr_valid);
    end
  endtask

  task automatic test_reset_midflight();
    int base;
    apply_reset();
    base = ovf_pulses;
    press({LOAD, 15'h0011}, 10);
    press({ADD, 15'h0022}, 10);
    press({SUB, 15'h0033}, 10);
    checks++;
    if (fifo_count !== 3'd3) begin
      failures++; $display("FAIL mid_prefill: got count=%0d expected 3", fifo_count);
    end
    switches = {MULT, 15'h4545};
    send_n = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (fifo_count !== 3'd0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_clear: got count=%0d valid=%b expected 0 and 0", fifo_count, instr_valid);
    end
    checks++;
    if (instr !== 18'h0) begin
      failures++; $display("FAIL mid_reset_instr: got %h expected 00000", instr);
    end
    reset = 1'b0;
    repeat (6) tick();
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL mid_held_early: got valid=%b expected 0", instr_valid);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr !== {MULT, 15'h4545}) begin
      failures++;
      $display("FAIL mid_held_accept: got valid=%b instr=%h expected 1 and %h", instr_valid, instr, {MULT, 15'h4545});
    end
    repeat (10) tick();
    send_n = 1'b1;
    repeat (12) tick();
    checks++;
    if (fifo_count !== 3'd1 || ovf_pulses - base !== 0) begin
      failures++;
      $display("FAIL mid_single_accept: got count=%0d ovf=%0d expected 1 and 0", fifo_count, ovf_pulses - base);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_overflow();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
